// File: rtl/serial_master_port.sv
// Serial bus master endpoint: serialises a config frame on control,
// then streams write words on wD or collects read words from rD.
module serial_master_port #(
  parameter int ADDR_DEPTH = 2000,
  parameter int SLAVES     = 3,
  parameter int DATA_WIDTH = 32,
  parameter int SLAVEID    = $clog2(SLAVES),
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 255,
  localparam int ADDR_WIDTH = $clog2(ADDR_DEPTH),
  localparam int LEN_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  rw,
  input  logic                  burst,
  input  logic [SLAVEID-1:0]    slave_sel,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  control,
  output logic                  wD,
  output logic                  valid,
  output logic                  last,
  input  logic                  rD,
  input  logic                  ready
);

  localparam int CFG_LEN = 5 + SLAVEID + ADDR_WIDTH;
  localparam int CW      = $clog2(CFG_LEN);
  localparam int BW      = $clog2(DATA_WIDTH);
  localparam int TW      = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_WAIT,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CFG_LEN-1:0]    r_frame;
  logic                  r_rw;
  logic [CW-1:0]         r_idx;
  logic [TW-1:0]         r_tmo;
  logic                  r_low;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit;
  logic [LEN_W-1:0]      r_words;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_err;

  logic                  w_final;
  logic                  w_word_end;
  logic                  w_go;
  logic                  w_timeout;
  logic [LEN_W-1:0]      w_len;

  assign w_final    = (r_words == LEN_W'(1));
  assign w_word_end = (r_bit == BW'(DATA_WIDTH - 1));

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign err      = r_err;
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);

  // Single transfers and zero-length bursts both move exactly one word
  always_comb begin
    w_len = LEN_W'(1);
    if (burst && (burst_len != '0)) begin
      if (burst_len > LEN_W'(MAX_BURST)) w_len = LEN_W'(MAX_BURST);
      else                               w_len = burst_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_go      = 1'b0;
    w_timeout = 1'b0;
    wr_req    = 1'b0;
    control   = 1'b0;
    wD        = 1'b0;
    valid     = 1'b0;
    last      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CONFIG;
      end
      S_CONFIG: begin
        control = r_frame[r_idx];
        if (r_idx == '0) w_next = S_WAIT;
      end
      S_WAIT: begin
        // reads need the slave to drop ready (fetch) before raising it
        w_go   = r_rw ? ready : (r_low && ready);
        wr_req = r_rw && ready;
        if (w_go) begin
          w_next = r_rw ? S_WRITE : S_READ;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_WRITE: begin
        valid = 1'b1;
        wD    = r_shift[DATA_WIDTH-1];
        last  = w_final;
        if (w_word_end) begin
          if (w_final) w_next = S_DONE;
          else         wr_req = 1'b1;
        end
      end
      S_READ: begin
        last = w_final;
        if (ready && w_word_end && w_final) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_frame    <= '0;
      r_rw       <= 1'b0;
      r_idx      <= '0;
      r_tmo      <= '0;
      r_low      <= 1'b0;
      r_shift    <= '0;
      r_bit      <= '0;
      r_words    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_frame <= {3'b111, slave_sel, rw, burst, start_addr};
            r_rw    <= rw;
            r_words <= w_len;
            r_idx   <= CW'(CFG_LEN - 1);
            r_err   <= 1'b0;
          end
        end
        S_CONFIG: begin
          r_idx <= r_idx - CW'(1);
          r_tmo <= '0;
          r_low <= 1'b0;
        end
        S_WAIT: begin
          r_tmo <= r_tmo + TW'(1);
          r_bit <= '0;
          if (!ready)           r_low   <= 1'b1;
          if (r_rw && ready)    r_shift <= wr_data;
          if (w_timeout)        r_err   <= 1'b1;
        end
        S_WRITE: begin
          if (w_word_end) begin
            r_bit <= '0;
            if (!w_final) begin
              r_words <= r_words - LEN_W'(1);
              r_shift <= wr_data;
            end
          end else begin
            r_bit   <= r_bit + BW'(1);
            r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end
        S_READ: begin
          if (ready) begin
            r_shift <= {r_shift[DATA_WIDTH-2:0], rD};
            if (w_word_end) begin
              r_rd_data  <= {r_shift[DATA_WIDTH-2:0], rD};
              r_rd_valid <= 1'b1;
              r_bit      <= '0;
              if (!w_final) r_words <= r_words - LEN_W'(1);
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_master_port.sv
// Bench for serial_master_port: per-cycle expected traces built from
// the bus rules, compared on every negedge, plus literal pin checks.
module tb_serial_master_port;

  localparam int CFG  = 18;
  localparam int MAXT = 400;

  logic        clk = 1'b0;
  logic        resetn, start, rw, burst;
  logic [1:0]  slave_sel;
  logic [10:0] start_addr;
  logic [4:0]  burst_len;
  logic [31:0] wr_data, rd_data;
  logic        wr_req, rd_valid, busy, done, err;
  logic        control, wD, valid, last, rD, ready;

  always #5 clk = ~clk;

  serial_master_port dut (
    .clk(clk), .resetn(resetn), .start(start), .rw(rw),
    .burst(burst), .slave_sel(slave_sel),
    .start_addr(start_addr), .burst_len(burst_len),
    .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
    .control(control), .wD(wD), .valid(valid), .last(last),
    .rD(rD), .ready(ready)
  );

  logic        e_ctrl[MAXT], e_wd[MAXT], e_val[MAXT], e_last[MAXT];
  logic        e_wrq[MAXT], e_busy[MAXT], e_done[MAXT];
  logic        e_err[MAXT], e_rdv[MAXT];
  logic [31:0] e_rdd[MAXT], s_wdata[MAXT];
  logic        s_start[MAXT], s_ready[MAXT], s_rd[MAXT];
  logic        s_rstn[MAXT];
  logic [31:0] wl[16];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          chk = 1'b0;
  logic        cur_err;
  logic [31:0] cur_rdd;
  logic [17:0] cap_ctrl;
  logic [31:0] cap_wd;
  int          n_wrq, n_val, n_last, n_rdv, done_at;
  int          n;

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      cmp("control", 32'(control), 32'(e_ctrl[cyc]));
      cmp("wD", 32'(wD), 32'(e_wd[cyc]));
      cmp("valid", 32'(valid), 32'(e_val[cyc]));
      cmp("last", 32'(last), 32'(e_last[cyc]));
      cmp("wr_req", 32'(wr_req), 32'(e_wrq[cyc]));
      cmp("busy", 32'(busy), 32'(e_busy[cyc]));
      cmp("done", 32'(done), 32'(e_done[cyc]));
      cmp("err", 32'(err), 32'(e_err[cyc]));
      cmp("rd_valid", 32'(rd_valid), 32'(e_rdv[cyc]));
      cmp("rd_data", rd_data, e_rdd[cyc]);
      if (cyc >= 1 && cyc <= CFG) cap_ctrl = {cap_ctrl[16:0], control};
      if (valid) begin
        cap_wd = {cap_wd[30:0], wD};
        n_val++;
      end
      if (last) n_last++;
      if (wr_req) n_wrq++;
      if (rd_valid) n_rdv++;
      if (done && done_at < 0) done_at = cyc;
    end
  end

  function automatic logic [17:0] frame(input logic [1:0] sl,
      input logic r, input logic b, input logic [10:0] a);
    return {3'b111, sl, r, b, a};
  endfunction

  function automatic int eff(input logic b, input logic [4:0] len);
    if (!b || len == 5'd0) return 1;
    return int'(len);
  endfunction

  task automatic clear();
    for (int t = 0; t < MAXT; t++) begin
      e_ctrl[t] = 0; e_wd[t] = 0; e_val[t] = 0; e_last[t] = 0;
      e_wrq[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_rdv[t] = 0;
      e_err[t] = cur_err; e_rdd[t] = cur_rdd;
      s_start[t] = 0; s_ready[t] = 1; s_rd[t] = 0;
      s_wdata[t] = '0; s_rstn[t] = 1;
    end
  endtask

  task automatic set_cfg(input logic [1:0] sl, input logic r,
      input logic b, input logic [10:0] a, input logic [4:0] len);
    logic [17:0] f;
    f = frame(sl, r, b, a);
    s_start[0] = 1;
    slave_sel = sl; rw = r; burst = b;
    start_addr = a; burst_len = len;
    for (int i = 0; i < CFG; i++) e_ctrl[1+i] = f[CFG-1-i];
    for (int t = 1; t < MAXT; t++) e_err[t] = 0;
    cur_err = 0;
  endtask

  // start edge at 0, frame on 1..18, WAIT at 19, words from 20
  task automatic build_write(input logic [1:0] sl, input logic b,
      input logic [10:0] a, input logic [4:0] len, output int nn);
    int e, d, req, prev, p;
    clear();
    set_cfg(sl, 1'b1, b, a, len);
    e = eff(b, len);
    prev = -1;
    for (int k = 0; k < e; k++) begin
      req = (k == 0) ? 19 : 20 + 32 * (k - 1) + 31;
      e_wrq[req] = 1;
      for (int t = prev + 1; t <= req; t++) s_wdata[t] = wl[k];
      prev = req;
      for (int j = 0; j < 32; j++) begin
        p = 20 + 32 * k + j;
        e_val[p] = 1;
        e_wd[p] = wl[k][31-j];
        e_last[p] = (k == e - 1);
      end
    end
    for (int t = prev + 1; t < MAXT; t++) s_wdata[t] = wl[e-1];
    d = 20 + 32 * e;
    e_done[d] = 1;
    for (int t = 1; t < d; t++) e_busy[t] = 1;
    nn = d + 2;
  endtask

  // ready low 0..24, handshake high at 25, data bits from 26
  task automatic build_read(input logic [1:0] sl, input logic b,
      input logic [10:0] a, input logic [4:0] len, input int sw,
      input int sb, input int stl, output int nn);
    int e, t;
    clear();
    set_cfg(sl, 1'b0, b, a, len);
    e = eff(b, len);
    for (int u = 0; u <= 24; u++) s_ready[u] = 0;
    t = 26;
    for (int k = 0; k < e; k++) begin
      for (int j = 0; j < 32; j++) begin
        if (k == sw && j == sb) begin
          for (int s = 0; s < stl; s++) begin
            s_ready[t] = 0;
            s_rd[t] = ~wl[k][31-j];
            e_last[t] = (k == e - 1);
            t++;
          end
        end
        s_ready[t] = 1;
        s_rd[t] = wl[k][31-j];
        e_last[t] = (k == e - 1);
        if (j == 31) begin
          e_rdv[t+1] = 1;
          for (int u = t + 1; u < MAXT; u++) e_rdd[u] = wl[k];
        end
        t++;
      end
    end
    e_done[t] = 1;
    for (int u = 1; u < t; u++) e_busy[u] = 1;
    cur_rdd = wl[e-1];
    nn = t + 2;
  endtask

  task automatic build_timeout(output int nn);
    clear();
    set_cfg(2'd1, 1'b1, 1'b0, 11'd3, 5'd0);
    for (int t = 0; t < MAXT; t++) s_ready[t] = 0;
    for (int t = 1; t < 274; t++) e_busy[t] = 1;
    e_done[274] = 1;
    for (int t = 274; t < MAXT; t++) e_err[t] = 1;
    cur_err = 1;
    nn = 276;
  endtask

  task automatic run(input int nn);
    cap_ctrl = '0; cap_wd = '0;
    n_wrq = 0; n_val = 0; n_last = 0; n_rdv = 0; done_at = -1;
    for (int t = 0; t < nn; t++) begin
      start = s_start[t]; ready = s_ready[t]; rD = s_rd[t];
      wr_data = s_wdata[t]; resetn = s_rstn[t];
      cyc = t;
      chk = 1'b1;
      @(posedge clk);
      #1;
    end
    chk = 1'b0;
    start = 0; ready = 1; rD = 0; resetn = 1;
  endtask

  initial begin
    resetn = 0; start = 0; rw = 0; burst = 0;
    slave_sel = '0; start_addr = '0; burst_len = '0;
    wr_data = '0; rD = 0; ready = 1;
    cur_err = 0; cur_rdd = '0;
    repeat (3) @(posedge clk);
    #1;
    clear();
    run(4);

    // T1 single write
    wl[0] = 32'hDEADBEEF;
    build_write(2'd1, 1'b0, 11'd5, 5'd0, n);
    run(n);
    cmp("t1_frame", 32'(cap_ctrl), 32'h0003B005);
    cmp("t1_wd", cap_wd, 32'hDEADBEEF);
    cmp("t1_last", n_last, 32);

    // T2 single read
    wl[0] = 32'hA5A50F0F;
    build_read(2'd2, 1'b0, 11'd7, 5'd0, -1, 0, 0, n);
    run(n);
    cmp("t2_rd_data", rd_data, 32'hA5A50F0F);
    cmp("t2_rdv", n_rdv, 1);

    // T3 burst write of 4
    wl[0] = 32'h00000001; wl[1] = 32'h80000000;
    wl[2] = 32'hFFFFFFFF; wl[3] = 32'h5A5AC3C3;
    build_write(2'd1, 1'b1, 11'd10, 5'd4, n);
    run(n);
    cmp("t3_wrq", n_wrq, 4);
    cmp("t3_valid", n_val, 128);
    cmp("t3_last", n_last, 32);
    cmp("t3_lastword", cap_wd, 32'h5A5AC3C3);

    // T4 burst read of 3, 5-cycle stall mid word 2
    wl[0] = 32'h12345678; wl[1] = 32'h9ABCDEF0; wl[2] = 32'h0F1E2D3C;
    build_read(2'd0, 1'b1, 11'd100, 5'd3, 1, 16, 5, n);
    run(n);
    cmp("t4_rd_data", rd_data, 32'h0F1E2D3C);
    cmp("t4_rdv", n_rdv, 3);

    // T5 timeout, then next start clears err
    build_timeout(n);
    run(n);
    cmp("t5_done_at", done_at, 274);
    cmp("t5_err_hold", 32'(err), 32'd1);
    wl[0] = 32'hC0FFEE11;
    build_write(2'd2, 1'b0, 11'd1999, 5'd0, n);
    run(n);
    cmp("t5_err_clr", 32'(err), 32'd0);

    // T6 reset during word 2 of a 3-word write
    wl[0] = 32'h11111111; wl[1] = 32'h22222222; wl[2] = 32'h33333333;
    build_write(2'd1, 1'b1, 11'd20, 5'd3, n);
    s_rstn[62] = 0;
    run(63);
    cur_rdd = '0;
    cur_err = 0;
    clear();
    run(3);
    wl[0] = 32'h76543210;
    build_write(2'd0, 1'b0, 11'd42, 5'd0, n);
    run(n);
    cmp("t6_wd", cap_wd, 32'h76543210);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
